// File: rtl/sdr_out_arbiter.sv
// Round-robin merge of the three SDR datapath sample strobes (FIR, CIC/DDC, FM demod)
// into one channel-tagged ready/valid stream. Optional per-sample stamps: SDR_ARB_TIMESTAMP_EN.
module sdr_out_arbiter #(
    parameter int unsigned DW    = 21,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DW-1:0]    s0_data,
    input  logic             s0_valid,
    input  logic [DW-1:0]    s1_data,
    input  logic             s1_valid,
    input  logic [DW-1:0]    s2_data,
    input  logic             s2_valid,
    output logic [DW-1:0]    m_data,
    output logic [1:0]       m_ch,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2:0]       ovf,
    input  logic             ovf_clr,
`ifdef SDR_ARB_TIMESTAMP_EN
    output logic [15:0]      m_ts,
`endif
    output logic [CNT_W-1:0] drop_cnt0,
    output logic [CNT_W-1:0] drop_cnt1,
    output logic [CNT_W-1:0] drop_cnt2
);

    localparam int unsigned NCH  = 3;
    localparam int unsigned CH_W = 2;
`ifdef SDR_ARB_TIMESTAMP_EN
    localparam int unsigned TS_W = 16;
`endif
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CH_W-1:0]  RR_RESET = CH_W'(2);

    // Per-channel views of the source ports
    logic [DW-1:0]    s_data_c [NCH];
    logic [NCH-1:0]   s_valid_c;

    assign s_data_c[0] = s0_data;
    assign s_data_c[1] = s1_data;
    assign s_data_c[2] = s2_data;
    assign s_valid_c   = {s2_valid, s1_valid, s0_valid};

    logic [NCH-1:0]   hold_full;
    logic [DW-1:0]    hold_data [NCH];
    logic [CH_W-1:0]  rr_last;
    logic [CNT_W-1:0] drop_cnt [NCH];

    logic             load_ok_c;
    logic             gnt_any_c;
    logic [CH_W-1:0]  gnt_ch_c;
    logic [NCH-1:0]   drain_c;
    logic [NCH-1:0]   drop_c;

`ifdef SDR_ARB_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_cnt;
    logic [TS_W-1:0]  hold_ts [NCH];
`endif

    assign load_ok_c = !m_valid || m_ready;

    // First full hold after rr_last, wrapping modulo three
    always_comb begin
        gnt_any_c = 1'b0;
        gnt_ch_c  = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            if (!gnt_any_c && hold_full[CH_W'((int'(rr_last) + i) % int'(NCH))]) begin
                gnt_any_c = 1'b1;
                gnt_ch_c  = CH_W'((int'(rr_last) + i) % int'(NCH));
            end
        end
    end

    // A hold being drained this edge may accept a new sample without dropping
    always_comb begin
        drain_c = '0;
        if (load_ok_c && gnt_any_c) begin
            drain_c[gnt_ch_c] = 1'b1;
        end
        drop_c = s_valid_c & hold_full & ~drain_c;
    end

    // Hold stage: one sample per channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_full <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                hold_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                if (s_valid_c[k] && (!hold_full[k] || drain_c[k])) begin
                    hold_data[k] <= s_data_c[k];
                    hold_full[k] <= 1'b1;
                end else if (drain_c[k]) begin
                    hold_full[k] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= '0;
            rr_last <= RR_RESET;
        end else if (load_ok_c) begin
            if (gnt_any_c) begin
                m_valid <= 1'b1;
                m_data  <= hold_data[gnt_ch_c];
                m_ch    <= gnt_ch_c;
                rr_last <= gnt_ch_c;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Sticky overflow flags and saturating drop counters; a drop beats a same-edge clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                drop_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NCH); k++) begin
                ovf[k] <= ovf_clr ? drop_c[k] : (ovf[k] | drop_c[k]);
                if (drop_c[k]) begin
                    if (ovf_clr) begin
                        drop_cnt[k] <= CNT_W'(1);
                    end else if (drop_cnt[k] != CNT_MAX) begin
                        drop_cnt[k] <= drop_cnt[k] + CNT_W'(1);
                    end
                end else if (ovf_clr) begin
                    drop_cnt[k] <= '0;
                end
            end
        end
    end

    assign drop_cnt0 = drop_cnt[0];
    assign drop_cnt1 = drop_cnt[1];
    assign drop_cnt2 = drop_cnt[2];

`ifdef SDR_ARB_TIMESTAMP_EN
    // Free-running stamp captured with each accepted sample
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt <= '0;
            m_ts   <= '0;
            for (int k = 0; k < int'(NCH); k++) begin
                hold_ts[k] <= '0;
            end
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            for (int k = 0; k < int'(NCH); k++) begin
                if (s_valid_c[k] && (!hold_full[k] || drain_c[k])) begin
                    hold_ts[k] <= ts_cnt;
                end
            end
            if (load_ok_c && gnt_any_c) begin
                m_ts <= hold_ts[gnt_ch_c];
            end
        end
    end
`endif

endmodule
